clas_arbiter: RTL and testbench
===============================

# clas_arbiter

Two-requester arbiter and sequencer for the team's shared 16-bit carry-lookahead add/sub unit `clas_16bit`. The block instantiates one `clas_16bit` and accepts operations from two independent requesters over valid/ready handshakes. Each cycle it grants at most one requester and drives that requester's operands through the unit. The result is captured in a one-deep output register and returned with the winning requester's ID.

## Interface
Parameters:
- None. The datapath is fixed at 16 bits by the shared unit.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  2  — bit i: requester i presents an operation.
- `req_ready`  out  2  — bit i: requester i's operation is accepted this cycle.
- `sel0`, `sel1`  in  1  — per-requester operation: 0 = add, 1 = subtract.
- `a0`, `b0`, `a1`, `b1`  in  16  — per-requester operands.
- `rsp_valid`  out  1  — the output register holds a result.
- `rsp_ready`  in  1  — the consumer takes the result this cycle.
- `rsp_id`  out  1  — index of the requester that produced the result.
- `rsp_result`  out  16  — `a + b` or `a - b`, modulo 2^16.
- `rsp_c_out`  out  1  — carry out of `clas_16bit`.
  - Add: carry.
  - Subtract: 1 = no borrow (`a >= b` unsigned).

## Operation
- `can_accept = !rsp_valid | rsp_ready`. The output register is empty or is draining this cycle.
- Grant is combinational from `req_valid` and the priority state `last_grant`:
  - One requester valid: that requester is granted.
  - Both valid: see Configuration.
  - Neither valid: no grant.
- `req_ready[i] = grant[i] & can_accept`. At most one bit of `req_ready` is high in any cycle.
- Requesters must not make `req_valid` depend on `req_ready`. A requester holds its valid and operands stable until accepted.
- Operand mux feeds `clas_16bit` with `sel`/`a`/`b` of the granted requester. With no grant, requester 0's inputs are fed and the result is discarded.
- Two-state output FSM:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept while `rsp_ready` is high (back-to-back transfer).
  - FULL → EMPTY on `rsp_ready` with no accept.
  - FULL holds while `rsp_ready` is low; `rsp_*` stay stable.
- On accept, the output register loads `{id, result, c_out}` and `last_grant` updates to the granted index.
- `last_grant` does not change on cycles with no accept, including cycles where a request is stalled by a full output.

## Timing
- Latency: an operation accepted at edge N has `rsp_valid` = 1 after edge N, with its result.
- Throughput: one operation per cycle while `rsp_ready` is held high.
- Reset (at a synchronous `rst` edge):
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0x0000, `rsp_c_out` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
- `req_ready` is 0 for the whole cycle in which `rst` is high, regardless of `req_valid`.
- Reset mid-operation drops any held result. It is not re-emitted.
- Simultaneous drain and accept in FULL: the old result is consumed and the new result is loaded at the same edge. There is no bubble.
- Output full and `rsp_ready` low: `req_ready` = 0. Requests wait with no loss and no duplication.

## Configuration
- `CLAS_ARB_RR_EN` defined: round-robin arbitration.
  - Both valid: grant goes to `!last_grant`.
  - Guarantees alternation under continuous contention.
- `CLAS_ARB_RR_EN` undefined: fixed priority.
  - Both valid: requester 0 always wins.
  - `last_grant` is still maintained but does not affect the grant.
  - Requester 1 can starve under continuous requester 0 traffic.

## Test plan
- Add path:
  - Req0 `sel0`=0, `a0`=0x7FFF, `b0`=0x0001, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=0x8000, `rsp_c_out`=0.
  - Then `a0`=0xFFFF, `b0`=0x0001 → `rsp_result`=0x0000, `rsp_c_out`=1.
- Subtract path:
  - Req1 `sel1`=1, `a1`=0x0005, `b1`=0x0007 → `rsp_result`=0xFFFE, `rsp_c_out`=0, `rsp_id`=1.
  - `a1`=`b1`=0x1234 → `rsp_result`=0x0000, `rsp_c_out`=1.
- Contention with `CLAS_ARB_RR_EN` defined: both requesters valid continuously for 6 cycles after reset, `rsp_ready`=1 → `rsp_id` sequence 0,1,0,1,0,1, one response per cycle.
- Contention with `CLAS_ARB_RR_EN` undefined: same stimulus → `rsp_id` = 0 for all 6 results, `req_ready[1]` never asserted.
- Backpressure: hold `rsp_ready`=0 for 3 cycles with a result held and req0 valid →
  - `rsp_*` stable and `req_ready`=0 throughout.
  - On `rsp_ready`=1, the held result is drained and req0 is accepted in the same cycle.
  - The next cycle shows req0's result.
- Reset mid-stream: assert `rst` for 1 cycle while `rsp_valid`=1 and both requesters valid →
  - Next cycle `rsp_valid`=0, `rsp_result`=0x0000.
  - `req_ready` was 0 during the reset cycle.
  - The first post-reset tie goes to requester 0.

Source files
------------

// File: rtl/clas_arbiter.sv
// Purpose : two-requester arbiter feeding one shared 16-bit CLA add/sub unit, with the result held in a one-deep output register.
// Latency : 1 cycle. An op accepted at edge N is presented on rsp_* after edge N.
// Backpressure: req_ready is low while the output register is full and not draining. Drain and accept can happen in the same cycle.
//
// Ports: clk, rst (sync, active-high); req_valid[1:0]/req_ready[1:0] handshake;
//        sel0/a0/b0 and sel1/a1/b1 operands (sel: 0=add, 1=sub);
//        rsp_valid/rsp_ready handshake; rsp_id, rsp_result[15:0], rsp_c_out.
// Config : define CLAS_ARB_RR_EN for round-robin on ties. When it is not defined, requester 0 has fixed priority.

// Shared 16-bit carry-lookahead adder/subtractor. Subtract is computed as a + ~b + 1.
// c_out is the carry for add. For subtract, c_out = 1 means there was no borrow.
module clas_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] bx, g, p;
  logic [16:0] c;
  logic [3:0]  gg, gp;

  always_comb begin
    bx = b ^ {16{sub}};
    g  = a & bx;
    p  = a ^ bx;
    // Group generate/propagate for each 4-bit group.
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Group carries are computed by lookahead and do not ripple between groups.
    c     = '0;
    c[0]  = sub;
    c[4]  = gg[0] | (gp[0] & c[0]);
    c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
    c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
    c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);
    // Carries inside each group.
    for (int k = 0; k < 4; k++) begin
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
    sum   = p ^ c[15:0];
    c_out = c[16];
  end
endmodule

module clas_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic        sel0,
  input  logic        sel1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_c_out
);
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        id_q, id_d;
  logic [15:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        last_grant_q, last_grant_d;

  logic [1:0]  grant;
  logic        can_accept, accept, gnt_id;
  logic        op_sel;
  logic [15:0] op_a, op_b, alu_sum;
  logic        alu_cout;

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef CLAS_ARB_RR_EN
        grant = last_grant_q ? 2'b01 : 2'b10;
`else
        grant = 2'b01;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

  assign rsp_valid  = (state_q == ST_FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  // Nothing is accepted during the reset cycle. An op accepted then would be lost.
  assign req_ready  = rst ? 2'b00 : (grant & {2{can_accept}});
  assign accept     = |req_ready;
  assign gnt_id     = grant[1];

  // With no grant, requester 0's operands are fed to the unit and the result is ignored.
  assign op_sel = gnt_id ? sel1 : sel0;
  assign op_a   = gnt_id ? a1   : a0;
  assign op_b   = gnt_id ? b1   : b0;

  clas_16bit u_clas (
    .a     (op_a),
    .b     (op_b),
    .sub   (op_sel),
    .sum   (alu_sum),
    .c_out (alu_cout)
  );

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    result_d     = result_q;
    cout_d       = cout_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)         state_d = ST_FULL;
        else if (rsp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      id_d         = gnt_id;
      result_d     = alu_sum;
      cout_d       = alu_cout;
      last_grant_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      id_q         <= 1'b0;
      result_q     <= 16'h0000;
      cout_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      result_q     <= result_d;
      cout_q       <= cout_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_c_out  = cout_q;
endmodule

// File: tb/tb_clas_arbiter.sv
module tb_clas_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic        sel0, sel1;
  logic [15:0] a0, b0, a1, b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_c_out;
  logic [15:0] rsp_result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];   // {id, result, c_out}

  always #5 clk = ~clk;

  clas_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .sel0(sel0), .sel1(sel1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_c_out(rsp_c_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Inputs change 1ns after the rising edge. Checks are made on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: each completed response transfer is checked against the next expected entry.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got id=%0d res=%h c=%0d want none", rsp_id, rsp_result, rsp_c_out);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({rsp_id, rsp_result, rsp_c_out} !== e) begin
          n_bad++;
          $display("FAIL rsp: got id=%0d res=%h c=%0d want id=%0d res=%h c=%0d",
                   rsp_id, rsp_result, rsp_c_out, e[17], e[16:1], e[0]);
        end
      end
    end
  end

  logic [5:0] rr_ids;

  initial begin
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    sel0 = 1'b0; sel1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1;
    at_neg(); chk("req_ready_in_reset", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0; req_valid = 2'b00;
    at_neg();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_result", 32'(rsp_result), 32'h0);
    chk("reset_rsp_c_out", 32'(rsp_c_out), 32'h0);
    step();

    // Add path on requester 0.
    rsp_ready = 1'b1; req_valid = 2'b01; sel0 = 1'b0; a0 = 16'h7FFF; b0 = 16'h0001;
    exp_q.push_back({1'b0, 16'h8000, 1'b0});
    at_neg(); chk("add0_req_ready", 32'(req_ready), 32'h1);
    step();
    a0 = 16'hFFFF; b0 = 16'h0001;
    exp_q.push_back({1'b0, 16'h0000, 1'b1});
    step();
    // Subtract path on requester 1.
    req_valid = 2'b10; sel1 = 1'b1; a1 = 16'h0005; b1 = 16'h0007;
    exp_q.push_back({1'b1, 16'hFFFE, 1'b0});
    at_neg(); chk("sub1_req_ready", 32'(req_ready), 32'h2);
    step();
    a1 = 16'h1234; b1 = 16'h1234;
    exp_q.push_back({1'b1, 16'h0000, 1'b1});
    step();
    req_valid = 2'b00;
    step();

    // Contention: reset first so that requester 0 wins the first tie.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 2'b11;
    sel0 = 1'b0; a0 = 16'h0010; b0 = 16'h0001;   // 0x0011, c=0
    sel1 = 1'b1; a1 = 16'h0010; b1 = 16'h0001;   // 0x000F, c=1
`ifdef CLAS_ARB_RR_EN
    rr_ids = 6'b101010;   // bit k is the id of grant k: 0,1,0,1,0,1
`else
    rr_ids = 6'b000000;
`endif
    for (int k = 0; k < 6; k++) begin
      if (rr_ids[k]) exp_q.push_back({1'b1, 16'h000F, 1'b1});
      else           exp_q.push_back({1'b0, 16'h0011, 1'b0});
      at_neg(); chk("contend_req_ready", 32'(req_ready), rr_ids[k] ? 32'h2 : 32'h1);
      step();
    end
    req_valid = 2'b00;
    step();

    // Backpressure.
    req_valid = 2'b01; sel0 = 1'b0; a0 = 16'h0100; b0 = 16'h0001;
    exp_q.push_back({1'b0, 16'h0101, 1'b0});
    step();
    rsp_ready = 1'b0; a0 = 16'h0200; b0 = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_hold", {15'h0, rsp_id, rsp_result}, {15'h0, 1'b0, 16'h0101});
      step();
    end
    rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 16'h0203, 1'b0});
    at_neg(); chk("bp_drain_accept", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    step();

    // Reset while a result is held and both requesters are valid.
    req_valid = 2'b01; sel0 = 1'b1; a0 = 16'h0009; b0 = 16'h0002;
    step();
    rsp_ready = 1'b0; req_valid = 2'b11; rst = 1'b1;
    at_neg();
    chk("mid_rsp_valid_before", 32'(rsp_valid), 32'h1);
    chk("mid_req_ready_in_reset", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    sel0 = 1'b0; a0 = 16'h0003; b0 = 16'h0004;
    sel1 = 1'b0; a1 = 16'h0100; b1 = 16'h0100;
    exp_q.push_back({1'b0, 16'h0007, 1'b0});
    at_neg();
    chk("mid_rsp_valid_after", 32'(rsp_valid), 32'h0);
    chk("mid_rsp_result_after", 32'(rsp_result), 32'h0);
    chk("mid_first_tie", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    step();
    step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
